zigzag_reorder_buf: RTL and testbench

- Downstream neighbour of the DCT datapath inside fdct_zigzag.
- Accepts DCT coefficients from dct_mod in raster order (row-major, one per cycle).
- Emits each 8x8 block in JPEG zigzag order for the quantiser.
- Ping-pong double buffer (2 x 64 entries): one block is written while the previous block is read.

---
 rtl/zigzag_pkg.sv | 33 +++
 rtl/zz_bank_ram.sv | 32 +++
 rtl/zigzag_reorder_buf.sv | 173 +++++++++++++++++
 tb/tb_zigzag_reorder_buf.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// zigzag_pkg
// Shared definitions for the zigzag reorder buffer: block size, coefficient
// type, read-side FSM state encoding and the JPEG zigzag scan table that maps
// a zigzag index k to the raster (row-major) address inside an 8x8 block.
package zigzag_pkg;

    localparam int COEF_W = 12;
    localparam int BLK    = 64;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // ZZ[k] = raster address of the k-th coefficient in zigzag scan order
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_addr(input logic [5:0] k);
        return ZZ[k];
    endfunction

endpackage

// File: rtl/zz_bank_ram.sv
// zz_bank_ram
// One 64-entry coefficient bank: single synchronous write port, single
// asynchronous read port. Contents are not reset; validity is tracked by the
// owner through its bank-full flags.
//   clk    - system clock
//   we     - write enable
//   waddr  - raster write address
//   wdata  - coefficient to store
//   raddr  - read address (combinational read)
//   rdata  - coefficient at raddr
module zz_bank_ram #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [5:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [5:0]    raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [64];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/zigzag_reorder_buf.sv
// zigzag_reorder_buf
// Ping-pong reorder buffer between the DCT and the quantiser. Raster-order
// coefficients are written into one 64-entry bank while the other bank is
// read out in JPEG zigzag order through a registered output stage.
//   clk, rst    - clock, asynchronous active-high reset
//   din         - coefficient in raster order
//   din_valid   - din valid this cycle
//   din_ready   - buffer can accept din (current write bank not full)
//   din_sob     - start-of-block marker for raster coefficient 0
//   dout        - coefficient in zigzag order
//   dout_valid  - dout holds a valid coefficient
//   dout_ready  - downstream accepts dout
//   dout_last   - dout is zigzag index 63 of its block
//   sob_err     - one-cycle pulse on a start-of-block protocol mismatch
module zigzag_reorder_buf #(
    parameter int DW  = 12,
    parameter int BLK = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          din_sob,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          sob_err
);

    import zigzag_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(BLK - 1);

    logic [5:0]    wr_cnt;
    logic [5:0]    rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    rd_state_t     state;
    rd_state_t     state_nxt;

    logic          wr_fire;
    logic          wr_done;
    logic          can_load;
    logic          load;
    logic          rd_done;
    logic [5:0]    rd_addr;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rd_data;

    assign din_ready = !full[wr_bank];
    assign wr_fire   = din_valid && din_ready;
    assign wr_done   = wr_fire && (wr_cnt == LAST_IDX);
    assign can_load  = !dout_valid || dout_ready;
    assign rd_done   = load && (rd_cnt == LAST_IDX);
    assign rd_addr   = zz_addr(rd_cnt);
    assign rd_data   = rd_bank ? rdata1 : rdata0;

    zz_bank_ram #(.DW(DW)) u_bank0 (
        .clk   (clk),
        .we    (wr_fire && !wr_bank),
        .waddr (wr_cnt),
        .wdata (din),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    zz_bank_ram #(.DW(DW)) u_bank1 (
        .clk   (clk),
        .we    (wr_fire && wr_bank),
        .waddr (wr_cnt),
        .wdata (din),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // Write side. A mismatched start-of-block marker is only flagged; the
    // coefficient is still stored at the current count (no resync).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            sob_err <= 1'b0;
        end else begin
            sob_err <= wr_fire && (din_sob != (wr_cnt == 6'd0));
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
            end
            if (wr_done) begin
                wr_bank <= !wr_bank;
            end
        end
    end

    // Set and clear never target the same bank in one cycle: a write can
    // only complete into a non-full bank, a read only finishes a full one.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // Read FSM. IDLE loads the first coefficient in the same cycle it sees a
    // full bank, giving one cycle from the final write to valid output. At
    // the end of a block it stays in STREAM if the other bank is waiting.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = RD_STREAM;
                    load      = can_load;
                end
            end
            RD_STREAM: begin
                if (full[rd_bank] && can_load) begin
                    load = 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        state_nxt = full[!rd_bank] ? RD_STREAM : RD_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = RD_IDLE;
            end
        endcase
    end

    // Output register holds its contents while stalled; valid drops only when
    // a transfer completes without a replacement load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RD_IDLE;
            rd_cnt     <= '0;
            rd_bank    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                dout       <= rd_data;
                dout_valid <= 1'b1;
                dout_last  <= (rd_cnt == LAST_IDX);
                rd_cnt     <= rd_cnt + 6'd1;
                if (rd_cnt == LAST_IDX) begin
                    rd_bank <= !rd_bank;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// tb_zigzag_reorder_buf
// Directed self-checking bench for zigzag_reorder_buf. Each scenario task
// drives stimulus and compares against hand-derived expectations; expected
// zigzag streams are built from an independently written scan table.
module tb_zigzag_reorder_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        din_sob = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic        sob_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_valid_cyc = -1;
    int last_wr_cyc = -1;
    int r5_cyc = -1;

    logic [11:0] exp_q[$];
    logic [11:0] recv_q[$];

    int zz_ref [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    int spec_head [16] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5};
    int spec_tail [4]  = '{47, 55, 62, 63};

    zigzag_reorder_buf #(.DW(12), .BLK(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_sob    (din_sob),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .sob_err    (sob_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: blk*100 + raster index; mode 1: negative values incl. extremes
    function automatic logic [11:0] coef_val(input int mode, input int blk, input int r);
        if (mode == 0) return 12'(blk * 100 + r);
        if (r == 0) return 12'h800;
        if (r == 1) return 12'hFFF;
        return 12'(-(r * 31) - blk);
    endfunction

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    // Drives nwords raster coefficients; pushes the expected zigzag stream
    // once a block's 64th word has been accepted.
    task automatic drive_words(input int mode, input int first_blk, input int nwords,
                               input int sob_bad_at, output int stalls);
        int n, r, blk, guard;
        bit fire;
        n = 0; stalls = 0; guard = 0;
        while (n < nwords && guard < 4000) begin
            r   = n % 64;
            blk = first_blk + n / 64;
            din       = coef_val(mode, blk, r);
            din_sob   = (r == 0) || (r == sob_bad_at);
            din_valid = 1'b1;
            fire      = (din_ready === 1'b1);
            if (!fire) stalls++;
            @(posedge clk);
            #1;
            guard++;
            if (fire) begin
                if (r == 63) begin
                    for (int k = 0; k < 64; k++) exp_q.push_back(coef_val(mode, blk, zz_ref[k]));
                    last_wr_cyc = cyc;
                end
                if (r == 5) r5_cyc = cyc;
                n++;
            end
        end
        din_valid = 1'b0;
        din_sob   = 1'b0;
        n_checks++;
        if (n != nwords) begin
            n_fail++;
            $display("[TB] FAIL write_timeout: accepted %0d words, required %0d", n, nwords);
        end
    endtask

    // Collects nvals outputs (ready_mode 0: always ready, 1: random ready),
    // checking value, last flag and stability under stall.
    task automatic collect(input int nvals, input int ready_mode, output int gaps);
        int got, guard;
        bit prev_stall, prev_last, exp_last;
        logic [11:0] prev_dout, exp;
        got = 0; guard = 0; gaps = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_dout = '0;
        #1;
        while (got < nvals && guard < 3000) begin
            dout_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                n_checks++;
                if (dout_valid !== 1'b1 || dout !== prev_dout || dout_last !== prev_last) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold: got v=%b d=%0d l=%b, required v=1 d=%0d l=%b",
                             dout_valid, dout, dout_last, prev_dout, prev_last);
                end
            end
            if (dout_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (dout_valid === 1'b1 && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL extra_output: got %0d, required no output", dout);
                end else begin
                    exp = exp_q.pop_front();
                    exp_last = (got % 64 == 63);
                    n_checks++;
                    if (dout !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL dout[%0d]: got %0d, required %0d", got, dout, exp);
                    end
                    n_checks++;
                    if (dout_last !== exp_last) begin
                        n_fail++;
                        $display("[TB] FAIL dout_last[%0d]: got %b, required %b", got, dout_last, exp_last);
                    end
                end
                recv_q.push_back(dout);
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            prev_stall = (dout_valid === 1'b1) && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            if (got < nvals) begin
                @(posedge clk);
                #2;
                guard++;
            end
        end
        dout_ready = 1'b1;
        n_checks++;
        if (got != nvals) begin
            n_fail++;
            $display("[TB] FAIL read_timeout: received %0d values, required %0d", got, nvals);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_last !== 1'b0 ||
            sob_err !== 1'b0 || dout !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL %s: got rdy=%b v=%b l=%b e=%b d=%0d, required rdy=1 v=0 l=0 e=0 d=0",
                     tag, din_ready, dout_valid, dout_last, sob_err, dout);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        sync();
        check_reset_outputs("after_reset");
    endtask

    task automatic test_basic;
        int st, gaps;
        sync();
        recv_q.delete();
        first_valid_cyc = -1;
        fork
            drive_words(0, 0, 64, -1, st);
            collect(64, 0, gaps);
        join
        n_checks++;
        if (first_valid_cyc != last_wr_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL latency: first valid at cycle %0d, required %0d", first_valid_cyc, last_wr_cyc + 1);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (recv_q.size() < 64 || recv_q[i] !== 12'(spec_head[i])) begin
                n_fail++;
                $display("[TB] FAIL zz_head[%0d]: got %0d, required %0d", i,
                         (recv_q.size() > i) ? recv_q[i] : 12'hxxx, spec_head[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (recv_q.size() < 64 || recv_q[60 + i] !== 12'(spec_tail[i])) begin
                n_fail++;
                $display("[TB] FAIL zz_tail[%0d]: got %0d, required %0d", 60 + i,
                         (recv_q.size() > 60 + i) ? recv_q[60 + i] : 12'hxxx, spec_tail[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int st, gaps;
        sync();
        fork
            drive_words(0, 0, 192, -1, st);
            collect(192, 0, gaps);
        join
        n_checks++;
        if (st != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_din_ready: stall cycles %0d, required 0", st);
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_output_gaps: idle cycles %0d, required 0", gaps);
        end
    endtask

    task automatic test_backpressure;
        int st, gaps, leaked, bad_hold;
        sync();
        dout_ready = 1'b0;
        drive_words(0, 0, 128, -1, st);
        n_checks++;
        if (st != 0 || din_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_fill: stalls %0d din_ready %b, required stalls 0 din_ready 0", st, din_ready);
        end
        leaked = 0; bad_hold = 0;
        for (int i = 0; i < 8; i++) begin
            din = 12'd200; din_sob = 1'b1; din_valid = 1'b1;
            if (din_ready !== 1'b0) leaked++;
            if (dout_valid !== 1'b1 || dout !== 12'd0) bad_hold++;
            sync();
        end
        din_valid = 1'b0; din_sob = 1'b0;
        n_checks++;
        if (leaked != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_both_full: din_ready high %0d cycles, required 0", leaked);
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_frozen: dout not held at valid 0 for %0d cycles, required 0", bad_hold);
        end
        collect(128, 0, gaps);
        sync();
        n_checks++;
        if (din_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_restore: din_ready %b, required 1", din_ready);
        end
    endtask

    task automatic test_random_stall;
        int st, gaps;
        sync();
        fork
            drive_words(1, 0, 192, -1, st);
            collect(192, 1, gaps);
        join
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rand_leftover: %0d values undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_sob_err;
        int st, gaps, sob_cnt, sob_cyc;
        sync();
        sob_cnt = 0; sob_cyc = -1;
        fork
            drive_words(0, 1, 64, 5, st);
            collect(64, 0, gaps);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #3;
                    if (sob_err === 1'b1) begin
                        sob_cnt++;
                        sob_cyc = cyc;
                    end
                end
            end
        join
        n_checks++;
        if (sob_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL sob_err_count: pulses %0d cycles, required 1", sob_cnt);
        end
        n_checks++;
        if (sob_cyc != r5_cyc) begin
            n_fail++;
            $display("[TB] FAIL sob_err_timing: pulse at cycle %0d, required %0d", sob_cyc, r5_cyc);
        end
    endtask

    task automatic test_reset_mid_block;
        int st, gaps, stray;
        sync();
        dout_ready = 1'b0;
        drive_words(0, 3, 94, -1, st);
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 12'd300) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_hold: got v=%b d=%0d, required v=1 d=300", dout_valid, dout);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        recv_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sync();
        fork
            drive_words(0, 4, 64, -1, st);
            collect(64, 0, gaps);
        join
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            sync();
            if (dout_valid !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_stale: stray valid %0d, pending %0d, required 0 and 0", stray, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_sob_err();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
